// File: rtl/fetch_unit.sv
// Fetch stage: program counter, instruction register and decode handshake.
// Halts on misaligned or out-of-range fetch addresses until redirected.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] ia,
    input  logic [31:0] id,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault
);

    typedef enum logic {
        RUN,
        HALT
    } state_e;

    localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] opc_q, opc_d;
    logic        fault_q, fault_d;

    logic        fire;
    logic        bad_pc;
    logic        hs;

    assign ia        = pc_q;
    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_pc    = opc_q;
    assign fault     = fault_q;

    assign hs     = valid_q && out_ready;
    assign fire   = (state_q == RUN) && (!valid_q || out_ready)
                    && !redirect_valid;
    assign bad_pc = (pc_q[1:0] != 2'b00) || ((pc_q >> 2) >= DEPTH_W);

    // Next-state: redirect first, then fetch/fault, then plain consume.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        opc_d   = opc_q;
        fault_d = fault_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            state_d = RUN;
            fault_d = 1'b0;
        end else if (fire && bad_pc) begin
            state_d = HALT;
            fault_d = 1'b1;
            if (out_ready) begin
                valid_d = 1'b0;
            end
        end else if (fire) begin
            instr_d = id;
            opc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
        end else if (hs) begin
            valid_d = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= 32'h0;
            opc_q   <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
            fault_q <= fault_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: per-cycle vector table plus a handshake
// scoreboard of the words decode is expected to consume, in order.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] ia;
    logic [31:0] id;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;

    int total = 0;
    int bad   = 0;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_DEPTH (1024)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ia             (ia),
        .id             (id),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fault          (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mw(input int i);
        return 32'hA500_0000 | 32'(i * 17 + 3) | (32'(i) << 16);
    endfunction

    logic [31:0] mem [1024];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = mw(i);
    end
    assign id = ((ia >> 2) < 32'd1024) ? mem[ia[11:2]] : 32'hDEAD_BEEF;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_ia;
        logic        e_fault;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } sb_t;

    vec_t vq[$];
    sb_t  sbq[$];
    logic sb_on = 1'b0;

    task automatic add(input logic r, input logic rv, input logic [31:0] rpc,
                       input logic rdy, input logic ev, input logic [31:0] ei,
                       input logic [31:0] ep, input logic [31:0] ea,
                       input logic ef);
        vec_t v;
        v.rst = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.e_valid = ev; v.e_instr = ei; v.e_pc = ep;
        v.e_ia = ea; v.e_fault = ef;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input int cyc,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic push_sb(input logic [31:0] ins, input logic [31:0] p);
        sb_t s;
        s.instr = ins;
        s.pc = p;
        sbq.push_back(s);
    endtask

    // Consumption monitor: a handshake seen mid-cycle completes at the next edge.
    always @(negedge clk) begin
        if (sb_on && !rst && out_valid && out_ready) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL sb_extra got=%h@%h want=none", out_instr, out_pc);
            end else begin
                sb_t s;
                s = sbq.pop_front();
                if (out_instr !== s.instr || out_pc !== s.pc) begin
                    bad++;
                    $display("FAIL sb_word got=%h@%h want=%h@%h",
                             out_instr, out_pc, s.instr, s.pc);
                end
            end
        end
    end

    initial begin
        // reset, stream, backpressure
        add(1, 0, 0,     1, 0, 0,      0,     32'h0,   0);
        add(0, 0, 0,     1, 1, mw(0),  0,     32'h4,   0);
        add(0, 0, 0,     1, 1, mw(1),  4,     32'h8,   0);
        add(0, 0, 0,     0, 1, mw(1),  4,     32'h8,   0);
        add(0, 0, 0,     0, 1, mw(1),  4,     32'h8,   0);
        add(0, 0, 0,     0, 1, mw(1),  4,     32'h8,   0);
        add(0, 0, 0,     1, 1, mw(2),  8,     32'hC,   0);
        // redirect to 0x40 while A2 is consumed
        add(0, 1, 32'h40, 1, 0, mw(2), 8,     32'h40,  0);
        add(0, 0, 0,     1, 1, mw(16), 32'h40, 32'h44, 0);
        // misaligned redirect target
        add(0, 1, 32'h42, 1, 0, mw(16), 32'h40, 32'h42, 0);
        add(0, 0, 0,     1, 0, mw(16), 32'h40, 32'h42, 1);
        add(0, 0, 0,     1, 0, mw(16), 32'h40, 32'h42, 1);
        add(0, 1, 32'h80, 1, 0, mw(16), 32'h40, 32'h80, 0);
        add(0, 0, 0,     1, 1, mw(32), 32'h80, 32'h84, 0);
        add(0, 0, 0,     0, 1, mw(32), 32'h80, 32'h84, 0);
        // reset during backpressure, with a simultaneous redirect
        add(1, 1, 32'h200, 0, 0, 0,    0,     32'h0,   0);
        // last word of memory, then out of range
        add(0, 1, 32'hFFC, 1, 0, 0,    0,     32'hFFC, 0);
        add(0, 0, 0,     1, 1, mw(1023), 32'hFFC, 32'h1000, 0);
        add(0, 0, 0,     1, 0, mw(1023), 32'hFFC, 32'h1000, 1);
        add(0, 0, 0,     1, 0, mw(1023), 32'hFFC, 32'h1000, 1);
        // reset during HALT, then restart
        add(1, 0, 0,     1, 0, 0,      0,     32'h0,   0);
        add(0, 0, 0,     1, 1, mw(0),  0,     32'h4,   0);

        push_sb(mw(0), 0);
        push_sb(mw(1), 4);
        push_sb(mw(2), 8);
        push_sb(mw(16), 32'h40);
        push_sb(mw(1023), 32'hFFC);
        push_sb(mw(0), 0);

        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        sb_on = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            rst = vq[i].rst;
            redirect_valid = vq[i].rv;
            redirect_pc = vq[i].rpc;
            out_ready = vq[i].rdy;
            @(posedge clk);
            #1;
            chk("valid", i, 32'(out_valid), 32'(vq[i].e_valid));
            chk("instr", i, out_instr, vq[i].e_instr);
            chk("pc",    i, out_pc,    vq[i].e_pc);
            chk("ia",    i, ia,        vq[i].e_ia);
            chk("fault", i, 32'(fault), 32'(vq[i].e_fault));
        end
        redirect_valid = 1'b0;
        @(negedge clk);
        #1;
        sb_on = 1'b0;
        chk("sb_left", -1, 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Fetch stage for the unpipelined fingerprint-recognition processor. It holds the program counter, drives the byte address into the combinational instruction memory, and captures the returned 32-bit word into an instruction register. It presents that register to decode with a valid/ready handshake. It also handles redirects from branch/jump resolution and halts on out-of-range or misaligned fetch addresses.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_DEPTH, 1024, number of 32-bit words in instruction memory; a fetch at word index >= IMEM_DEPTH faults.
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ia  out  32  byte address to instruction memory; always equals the PC register.
- id  in  32  instruction word returned combinationally for `ia`.
- redirect_valid  in  1  load `redirect_pc` into the PC this cycle.
- redirect_pc  in  32  redirect target byte address.
- out_valid  out  1  instruction register holds a valid instruction.
- out_ready  in  1  decode accepts the instruction this cycle.
- out_instr  out  32  registered instruction word.
- out_pc  out  32  byte address the instruction was fetched from.
- fault  out  1  sticky fetch fault; high while in HALT.

## Operation
- States:
  - RUN: normal fetch.
  - HALT: fault seen; no fetch.
- fire = (state==RUN) && (!out_valid || out_ready) && !redirect_valid.
- Fault check applies on any cycle where fire would be true.
  - Condition: pc[1:0]!=0, or (pc>>2) >= IMEM_DEPTH.
  - Action: go to HALT, fault<=1, no capture, PC unchanged, out_valid<=0 if out_ready, else hold.
- Good fire: out_instr<=id, out_pc<=pc, out_valid<=1, pc<=pc+4. The add is 32-bit modulo 2^32.
- Handshake completes when out_valid && out_ready. With no fire in that cycle, out_valid<=0.
- Backpressure: when out_valid=1 and out_ready=0, the PC, out_instr, out_pc and out_valid all hold.
- Redirect has highest priority below rst, in either state:
  - pc<=redirect_pc, out_valid<=0 (flush; a word handshaked in that same cycle still counts as consumed).
  - state<=RUN, fault<=0.
  - No capture that cycle.
- The redirect target is fault-checked only when it is fetched, on the next cycle.
- HALT is exited only by redirect or rst.

## Timing
- Reset values:
  - pc=RESET_PC, so ia=RESET_PC
  - out_valid=0, out_instr=0, out_pc=0
  - fault=0, state=RUN
- Latency from PC to out_instr is 1 cycle. The first valid instruction appears on the cycle after the first rising edge with rst=0.
- Throughput is 1 instruction/cycle with out_ready held high.
- Redirect costs one bubble: the redirect edge leaves out_valid=0, and the next edge shows the instruction at redirect_pc.
- rst mid-operation overrides everything, including a simultaneous redirect.
- ia is combinational from the PC register only; there is no path from id, redirect or ready to ia.

## Test plan
- Reset/stream:
  - Stimulus: mem[0..3]=A0..A3, out_ready=1, release rst.
  - Required: out_valid rises 1 cycle later, out_instr A0,A1,A2,A3 on consecutive cycles, out_pc 0,4,8,12.
- Backpressure:
  - Stimulus: drop out_ready for 3 cycles while out_valid=1 holding A1.
  - Required: out_instr=A1, out_pc=4 and ia=8 stable; A2 follows immediately once ready returns.
- Redirect:
  - Stimulus: redirect_valid with redirect_pc=0x40 while A2 is valid and out_ready=1.
  - Required: next cycle out_valid=0; following cycle out_instr=mem[16], out_pc=0x40; A3 never appears.
- Misaligned:
  - Stimulus: redirect_pc=0x42.
  - Required: fault=1 two cycles later, out_valid=0, ia holds 0x42; a redirect to 0x80 clears fault and mem[32] is delivered.
- Out of range:
  - Stimulus: RESET_PC=4*1023, IMEM_DEPTH=1024.
  - Required: mem[1023] delivered, then fault=1 with ia=0x1000 and no further out_valid.
- Reset during HALT and during backpressure:
  - Stimulus: assert rst in each condition.
  - Required: all outputs return to reset values on the next edge.
